div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Rst  input  1  reset, asynchronous, active-high.
REQ-003 Start  input  1  request a divide; sampled only in IDLE.
REQ-004 Signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with Start.
REQ-005 A  input  32  dividend; sampled with Start.
REQ-006 B  input  32  divisor; sampled with Start.
REQ-007 Busy  output  1  high while an operation is in progress (RUN state).
REQ-008 Done  output  1  one-cycle pulse when results become valid.
REQ-009 Quotient  output  32  result destined for LO.
REQ-010 Remainder  output  32  result destined for HI.
REQ-011 DivByZero  output  1  high with results when the captured B was 0; held until the next accepted Start.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE with Start=1 SHALL capture A, B and Signed, and SHALL go to RUN; if B=0, it SHALL go to DONE instead.
REQ-014 Capture SHALL convert operands to magnitudes: |A| and |B| when Signed=1, otherwise raw values; quotient sign = A[31]^B[31] and remainder sign = A[31] SHALL be stored.
REQ-015 RUN SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, counted by a 6-bit counter that is loaded with 0 on capture.
REQ-016 Each step SHALL compute {rem,quo} shifted left 1, then trial = rem - divisor on 33 bits; if trial is non-negative, rem <= trial and quo[0] <= 1.
REQ-017 After the 32nd step the block SHALL go to DONE.
REQ-018 On entry to DONE the block SHALL apply sign correction: Quotient is negated if the quotient sign is set, and Remainder is negated if the remainder sign is set (signed mode only).
REQ-019 Signed results SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-020 DONE SHALL last one cycle with Done=1 and Busy=0, then return to IDLE.
REQ-021 Latency SHALL be 34 rising edges from the Start sample to the Done pulse (1 capture, 32 RUN, 1 DONE).
REQ-022 For B=0: Done SHALL pulse 2 edges after Start, Quotient = 0xFFFFFFFF, Remainder = A as captured (unmodified), and DivByZero = 1.
REQ-023 For signed 0x80000000 / 0xFFFFFFFF the block SHALL produce Quotient = 0x80000000, Remainder = 0, and no error flag.
REQ-024 Start asserted while Busy=1 or in DONE SHALL be ignored; operands in flight SHALL NOT change.
REQ-025 Quotient, Remainder and DivByZero SHALL hold their last values in IDLE until the next Done; A and B changing after capture SHALL NOT affect the result.
REQ-026 Busy SHALL be asserted combinationally from state (RUN only), and Done from state (DONE only).

Reset
REQ-027 Rst=1 SHALL force state IDLE, counter 0, Quotient 0, Remainder 0, DivByZero 0, Busy 0 and Done 0 immediately, regardless of Clk.
REQ-028 Rst asserted mid-RUN SHALL abort the operation with no Done pulse; the first Start after Rst deasserts SHALL be accepted normally.

Verification
REQ-029 DIVU A=100, B=7 -> Done on edge 34: Quotient=14, Remainder=2, DivByZero=0; Busy high for exactly 32 cycles.
REQ-030 DIV A=-7 (0xFFFFFFF9), B=2 -> Quotient=0xFFFFFFFD (-3), Remainder=0xFFFFFFFF (-1); the same operands with DIVU -> Quotient=0x7FFFFFFC, Remainder=1.
REQ-031 DIV A=0x80000000, B=0xFFFFFFFF -> Quotient=0x80000000, Remainder=0; DIVU A=0xFFFFFFFF, B=1 -> Quotient=0xFFFFFFFF, Remainder=0.
REQ-032 Any mode A=0x1234, B=0 -> Done 2 edges after Start: Quotient=0xFFFFFFFF, Remainder=0x1234, DivByZero=1.
REQ-033 Start re-pulsed with new operands at RUN cycle 10 -> ignored; the original result appears on the original schedule.
REQ-034 Rst pulsed at RUN cycle 20 -> all outputs are 0 with no Done; a new DIVU 9/3 then yields Quotient=3, Remainder=0 after 34 edges.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: 32-bit iterative restoring divider for DIV/DIVU.
// One capture cycle, 32 shift-subtract cycles, then one DONE cycle with
// sign-corrected results. Division by zero skips RUN and reports
// Quotient=all ones, Remainder=dividend.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_start                request a divide (sampled only in IDLE)
//   i_signed               1 = two's complement DIV, 0 = DIVU
//   i_a, i_b               dividend / divisor, sampled with i_start
//   o_busy                 high while in RUN
//   o_done                 one-cycle pulse in DONE
//   o_quotient             result for LO
//   o_remainder            result for HI
//   o_div_by_zero          captured divisor was 0; held until next start
module div_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder,
  output logic        o_div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [5:0]  r_count;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_div;
  logic        r_q_neg;
  logic        r_r_neg;

  logic        w_b_zero;
  logic        w_last;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_rem_sh;
  logic [32:0] w_trial;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_b_zero = (i_b == 32'd0);
  assign w_last   = (r_count == 6'd31);

  // Operand magnitudes; unsigned mode passes raw values through
  assign w_a_mag = (i_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
  assign w_b_mag = (i_signed && i_b[31]) ? (32'd0 - i_b) : i_b;

  // One restoring step: shift {rem,quo} left, trial-subtract on 33 bits.
  // rem < divisor keeps the shifted value below 2*divisor, so bit 32 of the
  // trial is a clean borrow flag.
  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_trial   = w_rem_sh - {1'b0, r_div};
  assign w_rem_nxt = w_trial[32] ? w_rem_sh[31:0] : w_trial[31:0];
  assign w_quo_nxt = {r_quo[30:0], ~w_trial[32]};

  // Sign correction applied as the final step is written out
  assign w_quo_fix = r_q_neg ? (32'd0 - w_quo_nxt) : w_quo_nxt;
  assign w_rem_fix = r_r_neg ? (32'd0 - w_rem_nxt) : w_rem_nxt;

  // Status decoded straight from the state register
  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_DONE);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next_state = w_b_zero ? S_DONE : S_RUN;
      S_RUN:  if (w_last)  w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count       <= 6'd0;
      r_quo         <= 32'd0;
      r_rem         <= 32'd0;
      r_div         <= 32'd0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      o_quotient    <= 32'd0;
      o_remainder   <= 32'd0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_count       <= 6'd0;
            r_quo         <= w_a_mag;
            r_rem         <= 32'd0;
            r_div         <= w_b_mag;
            r_q_neg       <= i_signed & (i_a[31] ^ i_b[31]);
            r_r_neg       <= i_signed & i_a[31];
            o_div_by_zero <= w_b_zero;
            if (w_b_zero) begin
              o_quotient  <= 32'hFFFF_FFFF;
              o_remainder <= i_a;
            end
          end
        end
        S_RUN: begin
          r_count <= r_count + 6'd1;
          r_quo   <= w_quo_nxt;
          r_rem   <= w_rem_nxt;
          if (w_last) begin
            o_quotient  <= w_quo_fix;
            o_remainder <= w_rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int unsigned MAX_LAT = 100;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic        i_signed = 1'b0;
  logic [31:0] i_a = 32'd0;
  logic [31:0] i_b = 32'd0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_signed      (i_signed),
    .i_a           (i_a),
    .i_b           (i_b),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Latency is reported as the index of the rising edge that samples Done
  // high, counting the Start-sampling edge as edge 1.
  task automatic run_and_check(input string tag, input vec_t v, input int repulse_at);
    int lat;
    int busy_n;
    bit seen;
    int exp_lat;
    int exp_busy;
    @(negedge i_clk);
    i_start  = 1'b1;
    i_signed = v.sgn;
    i_a      = v.a;
    i_b      = v.b;
    @(posedge i_clk);
    #1;
    i_start  = 1'b0;
    i_a      = $urandom;
    i_b      = $urandom;
    i_signed = ~v.sgn;
    lat = 1;
    busy_n = 0;
    seen = 0;
    while (lat <= int'(MAX_LAT)) begin
      if (o_done) begin
        seen = 1;
        break;
      end
      if (o_busy) busy_n++;
      if (lat == 1 && v.b != 32'd0) chk({tag, "_dbz_cleared"}, 32'(o_div_by_zero), 32'd0);
      if (lat == repulse_at) begin
        i_start = 1'b1;
        i_a     = 32'd50;
        i_b     = 32'd3;
      end else begin
        i_start = 1'b0;
      end
      @(posedge i_clk);
      #1;
      lat++;
    end
    i_start = 1'b0;
    exp_lat  = v.dbz ? 2 : 34;
    exp_busy = v.dbz ? 0 : 32;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat + 1), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    chk({tag, "_busy_in_done"}, 32'(o_busy), 32'd0);
    chk({tag, "_quotient"}, o_quotient, v.q);
    chk({tag, "_remainder"}, o_remainder, v.r);
    chk({tag, "_dbz"}, 32'(o_div_by_zero), 32'(v.dbz));
    // Start offered during DONE must be ignored
    i_start = 1'b1;
    i_a     = 32'd77;
    i_b     = 32'd5;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    chk({tag, "_done_width"}, 32'(o_done), 32'd0);
    chk({tag, "_start_in_done_ignored"}, 32'(o_busy), 32'd0);
    repeat (3) begin
      i_a = $urandom;
      i_b = $urandom;
      @(posedge i_clk);
    end
    #1;
    chk({tag, "_hold_q"}, o_quotient, v.q);
    chk({tag, "_hold_r"}, o_remainder, v.r);
    chk({tag, "_hold_dbz"}, 32'(o_div_by_zero), 32'(v.dbz));
  endtask

  vec_t vecs[13];

  initial begin
    int lat;
    bit done_after_rst;
    vec_t v9;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[5]  = '{1'b1, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
    vecs[6]  = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
    vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    vecs[9]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
    vecs[11] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[12] = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};

    // Reset state, asserted between clock edges
    #2;
    i_rst = 1'b1;
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_q", o_quotient, 32'd0);
    chk("rst_r", o_remainder, 32'd0);
    chk("rst_dbz", 32'(o_div_by_zero), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < 13; i++) run_and_check($sformatf("vec%0d", i), vecs[i], -1);

    // Start re-pulsed with different operands at RUN cycle 10
    run_and_check("repulse", vecs[0], 10);

    // Reset at RUN cycle 20 aborts the operation
    @(negedge i_clk);
    i_start  = 1'b1;
    i_signed = 1'b0;
    i_a      = 32'd100;
    i_b      = 32'd7;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("midrun_rst_busy", 32'(o_busy), 32'd0);
    chk("midrun_rst_done", 32'(o_done), 32'd0);
    chk("midrun_rst_q", o_quotient, 32'd0);
    chk("midrun_rst_r", o_remainder, 32'd0);
    chk("midrun_rst_dbz", 32'(o_div_by_zero), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    done_after_rst = 0;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      if (o_done || o_busy) done_after_rst = 1;
    end
    chk("no_done_after_abort", 32'(done_after_rst), 32'd0);
    chk("abort_q_stays_zero", o_quotient, 32'd0);

    v9 = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    run_and_check("after_rst_9div3", v9, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
